hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 16-bit, 5-stage MIPS core (IF, ID, EX, MEM, WB; 8 registers; 3-bit fields rs[12:10], rt[9:7], rd[6:4]).
- Sits beside the decode stage and tracks destination registers of in-flight instructions.
- Generates PC/IF-ID enables, flush/bubble controls and EX-stage forwarding selects.
- Resolves load-use hazards, taken-branch squashes and memory wait stalls.

---
 rtl/hazard_controller_if.sv | 36 +++
 rtl/hazard_controller.sv | 178 +++++++++++++++++
 tb/tb_hazard_controller.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Decode-side sequencing bus between the MIPS pipeline and hazard_controller.
// master drives the ID/EX/MEM status, slave (the controller) returns the enables and selects.
interface hazard_controller_if #(
    parameter int RW          = 3,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [RW-1:0]          id_rs;
    logic [RW-1:0]          id_rt;
    logic                   id_use_rs;
    logic                   id_use_rt;
    logic [RW-1:0]          id_dst;
    logic                   id_wr_en;
    logic                   id_is_load;
    logic                   ex_branch_taken;
    logic                   mem_busy;
    logic                   pc_en;
    logic                   ifid_en;
    logic                   ifid_flush;
    logic                   idex_bubble;
    logic [1:0]             ex_fwd_a;
    logic [1:0]             ex_fwd_b;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr_en,
               id_is_load, ex_branch_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, ex_fwd_a, ex_fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr_en,
               id_is_load, ex_branch_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_bubble, ex_fwd_a, ex_fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for the 16-bit 5-stage MIPS core.
// FORWARDING_EN defined: EX forwarding, only load-use stalls; undefined: stall until producer hits WB.
module hazard_controller #(
    parameter int RW          = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_controller_if.slave bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    // Shadow pipeline: _p0 = EX, _p1 = MEM, _p2 = WB
    logic          r_vld_p0, r_vld_p1, r_vld_p2;
    logic [RW-1:0] r_dst_p0, r_dst_p1, r_dst_p2;
    logic          r_wr_p0,  r_wr_p1,  r_wr_p2;
    logic          r_ld_p0,  r_ld_p1,  r_ld_p2;

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    state_t w_state;
    logic   w_pc_en;
    logic   w_ifid_en;
    logic   w_ifid_flush;
    logic   w_idex_bubble;
    logic   w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    logic   w_hazard;

    function automatic logic src_match(
        input logic          use_src,
        input logic [RW-1:0] src,
        input logic          vld,
        input logic [RW-1:0] dst,
        input logic          wr
    );
        return use_src && vld && wr && (src != '0) && (src == dst);
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_ex_rs  = src_match(bus.id_use_rs, bus.id_rs, r_vld_p0, r_dst_p0, r_wr_p0);
    assign w_ex_rt  = src_match(bus.id_use_rt, bus.id_rt, r_vld_p0, r_dst_p0, r_wr_p0);
    assign w_mem_rs = src_match(bus.id_use_rs, bus.id_rs, r_vld_p1, r_dst_p1, r_wr_p1);
    assign w_mem_rt = src_match(bus.id_use_rt, bus.id_rt, r_vld_p1, r_dst_p1, r_wr_p1);

`ifdef FORWARDING_EN
    assign w_hazard = bus.id_valid && r_ld_p0 && (w_ex_rs || w_ex_rt);
`else
    assign w_hazard = bus.id_valid && (w_ex_rs || w_ex_rt || w_mem_rs || w_mem_rt);
`endif

    // The decision is re-derived every cycle from live inputs and shadow contents
    always_comb begin
        w_state       = RUN;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;

        if (bus.mem_busy) begin
            w_state = MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
            w_state = FLUSH;
        end else if (w_hazard) begin
            w_state = LOAD_STALL;
        end

        case (w_state)
            LOAD_STALL: begin
                w_pc_en       = 1'b0;
                w_ifid_en     = 1'b0;
                w_idex_bubble = 1'b1;
            end
            FLUSH: begin
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
            end
            MEM_WAIT: begin
                w_pc_en   = 1'b0;
                w_ifid_en = 1'b0;
            end
            default: ;
        endcase

        if (rst) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end
    end

    // ID -> EX -> MEM -> WB shadow advance; everything holds while memory is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (!bus.mem_busy) begin
            r_vld_p0 <= bus.id_valid && !w_idex_bubble;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.mem_busy) begin
            r_dst_p0 <= bus.id_dst;
            r_wr_p0  <= bus.id_wr_en;
            r_ld_p0  <= bus.id_is_load;
            r_dst_p1 <= r_dst_p0;
            r_wr_p1  <= r_wr_p0;
            r_ld_p1  <= r_ld_p0;
            r_dst_p2 <= r_dst_p1;
            r_wr_p2  <= r_wr_p1;
            r_ld_p2  <= r_ld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] r_fwd_a_p0, r_fwd_b_p0;

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        return ex_hit ? 2'b01 : (mem_hit ? 2'b10 : 2'b00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_a_p0 <= 2'b00;
            r_fwd_b_p0 <= 2'b00;
        end else if (!bus.mem_busy) begin
            if (w_idex_bubble || !bus.id_valid) begin
                r_fwd_a_p0 <= 2'b00;
                r_fwd_b_p0 <= 2'b00;
            end else begin
                r_fwd_a_p0 <= fwd_sel(w_ex_rs, w_mem_rs);
                r_fwd_b_p0 <= fwd_sel(w_ex_rt, w_mem_rt);
            end
        end
    end

    assign bus.ex_fwd_a = r_fwd_a_p0;
    assign bus.ex_fwd_b = r_fwd_b_p0;

    // WB never raises a hazard (write-before-read regfile); is_load only matters in EX
    logic w_unused_shadow;
    assign w_unused_shadow = ^{r_vld_p2, r_dst_p2, r_wr_p2, r_ld_p2, r_ld_p1};
`else
    assign bus.ex_fwd_a = 2'b00;
    assign bus.ex_fwd_b = 2'b00;

    logic w_unused_shadow;
    assign w_unused_shadow = ^{r_vld_p2, r_dst_p2, r_wr_p2, r_ld_p2, r_ld_p1, r_ld_p0};
`endif

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; stall counter narrowed to 4 bits so saturation is reachable.
module tb_hazard_controller;
    localparam int RW = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_controller_if #(.RW(RW), .STALL_CNT_W(CW)) hif();

    hazard_controller #(.RW(RW), .STALL_CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0]    fwd_q[$];
    logic [CW-1:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic id_in(input logic v, input logic [2:0] rs, input logic urs,
                         input logic [2:0] rt, input logic urt, input logic [2:0] dst,
                         input logic wr, input logic ld);
        hif.id_valid   = v;
        hif.id_rs      = rs;
        hif.id_use_rs  = urs;
        hif.id_rt      = rt;
        hif.id_use_rt  = urt;
        hif.id_dst     = dst;
        hif.id_wr_en   = wr;
        hif.id_is_load = ld;
    endtask

    task automatic nop_in();
        id_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // One clock: combinational outputs at negedge, registered outputs just after posedge
    task automatic step(input string tag, input logic pc, input logic ifid, input logic fl,
                        input logic bub, input logic [1:0] fa, input logic [1:0] fb);
        logic [3:0] e;
        @(negedge clk);
        chk({tag, ".pc_en"}, {7'd0, hif.pc_en}, {7'd0, pc});
        chk({tag, ".ifid_en"}, {7'd0, hif.ifid_en}, {7'd0, ifid});
        chk({tag, ".ifid_flush"}, {7'd0, hif.ifid_flush}, {7'd0, fl});
        chk({tag, ".idex_bubble"}, {7'd0, hif.idex_bubble}, {7'd0, bub});
        fwd_q.push_back({fa, fb});
        @(posedge clk);
        #1;
        if (rst) exp_cnt = '0;
        else if (!pc && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        e = fwd_q.pop_front();
        chk({tag, ".fwd_a"}, {6'd0, hif.ex_fwd_a}, {6'd0, e[3:2]});
        chk({tag, ".fwd_b"}, {6'd0, hif.ex_fwd_b}, {6'd0, e[1:0]});
        chk({tag, ".stall_cnt"}, {4'd0, hif.stall_cnt}, {4'd0, exp_cnt});
    endtask

    task automatic run(input string tag, input logic [1:0] fa, input logic [1:0] fb);
        step(tag, 1'b1, 1'b1, 1'b0, 1'b0, fa, fb);
    endtask
    task automatic stall(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    endtask
    task automatic flush(input string tag);
        step(tag, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
    endtask
    task automatic mwait(input string tag, input logic [1:0] fa, input logic [1:0] fb);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb);
    endtask
    task automatic resetc(input string tag);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    endtask
    task automatic drain();
        nop_in();
        run("drain0", 2'b00, 2'b00);
        run("drain1", 2'b00, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        hif.ex_branch_taken = 1'b0;
        hif.mem_busy = 1'b0;
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        resetc("rst0");
        resetc("rst1");
        rst = 1'b0;
        nop_in();
        run("idle", 2'b00, 2'b00);

        // ADD r3,r1,r2 then SUB r4,r3,r1
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        run("add_r3", 2'b00, 2'b00);
        id_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
`ifdef FORWARDING_EN
        run("sub_ex", 2'b01, 2'b00);
`else
        stall("sub_ex0");
        stall("sub_ex1");
        run("sub_ex2", 2'b00, 2'b00);
`endif
        drain();

        // ADD r3, NOP, SUB r4,r3,r1
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        run("add_r3b", 2'b00, 2'b00);
        nop_in();
        run("gap", 2'b00, 2'b00);
        id_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
`ifdef FORWARDING_EN
        run("sub_mem", 2'b10, 2'b00);
`else
        stall("sub_mem0");
        run("sub_mem1", 2'b00, 2'b00);
`endif
        drain();

        // Destination r0 never matches
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b1, 1'b0);
        run("add_r0", 2'b00, 2'b00);
        id_in(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0);
        run("use_r0", 2'b00, 2'b00);
        drain();

        // LW r2,(r1) then ADD r5,r1,r2
        id_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        run("lw", 2'b00, 2'b00);
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
`ifdef FORWARDING_EN
        stall("lu_stall");
        run("lu_fwd", 2'b00, 2'b10);
`else
        stall("lu_stall0");
        stall("lu_stall1");
        run("lu_go", 2'b00, 2'b00);
`endif
        drain();

        // Taken branch beats a pending load-use
        id_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        run("lw_b", 2'b00, 2'b00);
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
        hif.ex_branch_taken = 1'b1;
        flush("br_lu");
        hif.ex_branch_taken = 1'b0;
        drain();

        // Memory wait mid-stream: selects and shadows hold
`ifdef FORWARDING_EN
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        run("mw_add", 2'b00, 2'b00);
        id_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
        run("mw_sub", 2'b01, 2'b00);
        id_in(1'b1, 3'd4, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 1'b0);
        hif.mem_busy = 1'b1;
        mwait("mw0", 2'b01, 2'b00);
        mwait("mw1", 2'b01, 2'b00);
        mwait("mw2", 2'b01, 2'b00);
        hif.mem_busy = 1'b0;
        run("mw_and", 2'b01, 2'b10);
`else
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        run("mw_add", 2'b00, 2'b00);
        id_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
        hif.mem_busy = 1'b1;
        mwait("mw0", 2'b00, 2'b00);
        mwait("mw1", 2'b00, 2'b00);
        mwait("mw2", 2'b00, 2'b00);
        hif.mem_busy = 1'b0;
        stall("mw_ex");
        stall("mw_mem");
        run("mw_go", 2'b00, 2'b00);
`endif
        drain();

        // Long wait drives the stall counter into saturation
        hif.mem_busy = 1'b1;
        for (int i = 0; i < 16; i++) mwait("sat", 2'b00, 2'b00);
        chk("sat_max", {4'd0, hif.stall_cnt}, 8'h0F);
        hif.mem_busy = 1'b0;
        run("sat_exit", 2'b00, 2'b00);

        // Reset mid-operation discards the tracked producer
        id_in(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0);
        run("pre_rst", 2'b00, 2'b00);
        id_in(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
        rst = 1'b1;
        resetc("rst_mid");
        rst = 1'b0;
        run("post_rst", 2'b00, 2'b00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
